// File: rtl/bitstream_pkg.sv
// Shared constants, FSM state encoding and burst-count helpers for the
// stage-5 bitstream output scheduler.
package bitstream_pkg;

  // Default width of one bitstream byte
  localparam int unsigned DEF_BYTE_WIDTH = 8;

  // Largest burst stage 4 can emit in one cycle
  localparam int unsigned BURST_MAX = 5;

  // Width of the per-cycle byte count
  localparam int unsigned CNT_W = 3;

  // End-of-frame sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  // A count that names real burst bytes (1..BURST_MAX)
  function automatic logic burst_count_legal(input logic [CNT_W-1:0] cnt);
    return (cnt != '0) && (cnt <= CNT_W'(BURST_MAX));
  endfunction

  // A count the encoding can carry but stage 4 never legally produces
  function automatic logic burst_count_illegal(input logic [CNT_W-1:0] cnt);
    return cnt > CNT_W'(BURST_MAX);
  endfunction

endpackage

// File: rtl/byte_fifo_multi_write.sv
// Circular byte buffer: up to BURST_MAX bytes written per cycle through a
// count-masked lane port, one byte read per cycle with first-word
// fall-through. The caller guarantees wr_count fits in the free space.
module byte_fifo_multi_write
  import bitstream_pkg::*;
#(
  parameter int unsigned BYTE_WIDTH  = DEF_BYTE_WIDTH,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned LEVEL_WIDTH = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wr_en,
  input  logic [CNT_W-1:0]                wr_count,
  input  logic [BURST_MAX*BYTE_WIDTH-1:0] wr_data,
  input  logic                            rd_ready,
  output logic [BYTE_WIDTH-1:0]           rd_data,
  output logic                            rd_valid,
  output logic [LEVEL_WIDTH-1:0]          level
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  logic [BYTE_WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [LEVEL_WIDTH-1:0] level_q;
  logic [CNT_W-1:0]       push_count;
  logic                   pop;

  assign rd_valid   = (level_q != '0);
  assign pop        = rd_valid & rd_ready;
  assign push_count = wr_en ? wr_count : '0;
  // Head byte is forced to zero when empty so the port never shows stale storage
  assign rd_data    = rd_valid ? mem[rd_ptr] : '0;
  assign level      = level_q;

  // Lane i lands at wr_ptr+i; pointer arithmetic wraps naturally in PTR_W bits
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < BURST_MAX; i++) begin
        if (CNT_W'(i) < wr_count) begin
          mem[wr_ptr + PTR_W'(i)] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Pointers and occupancy; write and pop may land on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      wr_ptr  <= wr_ptr + PTR_W'(push_count);
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      level_q <= level_q + LEVEL_WIDTH'(push_count) - LEVEL_WIDTH'(pop);
    end
  end

endmodule

// File: rtl/bitstream_output_scheduler.sv
// Stage-5 output scheduler: absorbs 0-5 byte bursts from stage 4 into a
// byte FIFO, streams them one byte per cycle to the sink, throttles the
// upstream pipeline, and sequences end-of-frame (flush, tag last, done).
module bitstream_output_scheduler
  import bitstream_pkg::*;
#(
  parameter int unsigned BYTE_WIDTH  = DEF_BYTE_WIDTH,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned LEVEL_WIDTH = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   s5_clk,
  input  logic                   s5_reset,
  input  logic [CNT_W-1:0]       in_carry_flag,
  input  logic [BYTE_WIDTH-1:0]  in_carry_bit_1,
  input  logic [BYTE_WIDTH-1:0]  in_carry_bit_2,
  input  logic [BYTE_WIDTH-1:0]  in_carry_bit_3,
  input  logic [BYTE_WIDTH-1:0]  in_carry_bit_4,
  input  logic [BYTE_WIDTH-1:0]  in_carry_bit_5,
  input  logic                   in_flag_last,
  input  logic                   in_sink_ready,
  output logic [BYTE_WIDTH-1:0]  out_byte,
  output logic                   out_valid,
  output logic                   out_last,
  output logic                   out_done,
  output logic                   out_stall,
  output logic [LEVEL_WIDTH-1:0] out_level,
  output logic                   out_overflow,
  output logic                   out_proto_err
);

  sched_state_e                  state;
  logic [LEVEL_WIDTH-1:0]        level;
  logic [LEVEL_WIDTH-1:0]        free;
  logic [BURST_MAX*BYTE_WIDTH-1:0] burst_data;
  logic                          accepting;
  logic                          count_nz;
  logic                          count_legal;
  logic                          fits;
  logic                          wr_en;
  logic                          overflow_q;
  logic                          proto_err_q;

  // Lane 0 carries bit_1, the first byte in stream order
  assign burst_data = {in_carry_bit_5, in_carry_bit_4, in_carry_bit_3,
                       in_carry_bit_2, in_carry_bit_1};

  assign free        = LEVEL_WIDTH'(FIFO_DEPTH) - level;
  assign accepting   = (state == ST_IDLE) || (state == ST_RUN);
  assign count_nz    = (in_carry_flag != '0);
  assign count_legal = burst_count_legal(in_carry_flag);
  assign fits        = (LEVEL_WIDTH'(in_carry_flag) <= free);
  // Whole burst or nothing: a burst that does not fit is dropped entirely
  assign wr_en       = accepting & count_legal & fits;

  byte_fifo_multi_write #(
    .BYTE_WIDTH  (BYTE_WIDTH),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .LEVEL_WIDTH (LEVEL_WIDTH)
  ) u_fifo (
    .clk      (s5_clk),
    .rst_n    (s5_reset),
    .wr_en    (wr_en),
    .wr_count (in_carry_flag),
    .wr_data  (burst_data),
    .rd_ready (in_sink_ready),
    .rd_data  (out_byte),
    .rd_valid (out_valid),
    .level    (level)
  );

  assign out_level     = level;
  // Stall ignores a same-cycle pop so the decision depends only on registered level
  assign out_stall     = (free < LEVEL_WIDTH'(BURST_MAX));
  assign out_last      = out_valid && (state == ST_FLUSH) && (level == LEVEL_WIDTH'(1));
  assign out_done      = (state == ST_DONE);
  assign out_overflow  = overflow_q;
  assign out_proto_err = proto_err_q;

  // End-of-frame sequencer
  always_ff @(posedge s5_clk or negedge s5_reset) begin
    if (!s5_reset) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_flag_last) begin
            state <= ST_FLUSH;
          end else if (count_nz) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (in_flag_last) begin
            state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if ((out_last && in_sink_ready) || (level == '0)) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge s5_clk or negedge s5_reset) begin
    if (!s5_reset) begin
      overflow_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      if (accepting && count_legal && !fits) begin
        overflow_q <= 1'b1;
      end
      if (burst_count_illegal(in_carry_flag) || (!accepting && count_nz)) begin
        proto_err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bitstream_output_scheduler.sv
// Scoreboard bench for bitstream_output_scheduler: stimulus pushes the
// expected {last, byte} stream, a negedge monitor checks every handshake.
module tb_bitstream_output_scheduler;

  localparam int unsigned BW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned LW    = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    cnt;
  logic [BW-1:0] b1, b2, b3, b4, b5;
  logic          last;
  logic          ready;

  logic [BW-1:0] out_byte;
  logic          out_valid;
  logic          out_last;
  logic          out_done;
  logic          out_stall;
  logic [LW-1:0] out_level;
  logic          out_overflow;
  logic          out_proto_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] exp_q [$];

  always #5 clk = ~clk;

  bitstream_output_scheduler #(
    .BYTE_WIDTH (BW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .s5_clk        (clk),
    .s5_reset      (rst_n),
    .in_carry_flag (cnt),
    .in_carry_bit_1(b1),
    .in_carry_bit_2(b2),
    .in_carry_bit_3(b3),
    .in_carry_bit_4(b4),
    .in_carry_bit_5(b5),
    .in_flag_last  (last),
    .in_sink_ready (ready),
    .out_byte      (out_byte),
    .out_valid     (out_valid),
    .out_last      (out_last),
    .out_done      (out_done),
    .out_stall     (out_stall),
    .out_level     (out_level),
    .out_overflow  (out_overflow),
    .out_proto_err (out_proto_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one burst for one edge; expected bytes go to the scoreboard if it should be accepted
  task automatic burst(input int n, input logic [7:0] base, input logic lst, input logic accept);
    cnt  = 3'(n);
    b1   = base;
    b2   = base + 8'd1;
    b3   = base + 8'd2;
    b4   = base + 8'd3;
    b5   = base + 8'd4;
    last = lst;
    if (accept) begin
      for (int i = 0; i < n; i++) begin
        exp_q.push_back({(lst && (i == n - 1)), 8'(base + 8'(i))});
      end
    end
    tick();
    cnt  = '0;
    last = 1'b0;
  endtask

  // Drain with ready high, bounded by a cycle budget
  task automatic drain(input string name, input int budget);
    int k;
    k = 0;
    ready = 1'b1;
    while ((out_level != '0) && (k < budget)) begin
      tick();
      k++;
    end
    check(name, 32'(out_level), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ready = 1'b0;
    cnt   = '0;
    last  = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Monitor: every handshake must match the head of the scoreboard
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst_n && out_valid && ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_byte: got 0x%0h, expected no output", out_byte);
      end else begin
        e = exp_q.pop_front();
        check("stream_last_byte", {23'd0, out_last, out_byte}, {23'd0, e});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    cnt   = '0;
    last  = 1'b0;
    ready = 1'b0;
    b1 = '0; b2 = '0; b3 = '0; b4 = '0; b5 = '0;
    #2;
    // Reset state
    check("rst_valid",    32'(out_valid),     32'd0);
    check("rst_level",    32'(out_level),     32'd0);
    check("rst_byte",     32'(out_byte),      32'd0);
    check("rst_last",     32'(out_last),      32'd0);
    check("rst_done",     32'(out_done),      32'd0);
    check("rst_stall",    32'(out_stall),     32'd0);
    check("rst_overflow", 32'(out_overflow),  32'd0);
    check("rst_proto",    32'(out_proto_err), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Basic 3-byte burst with ready high
    ready = 1'b1;
    burst(3, 8'hA1, 1'b0, 1'b1);
    check("t1_level",  32'(out_level), 32'd3);
    check("t1_valid",  32'(out_valid), 32'd1);
    check("t1_head",   32'(out_byte),  32'hA1);
    drain("t1_drain", 10);
    check("t1_overflow", 32'(out_overflow),  32'd0);
    check("t1_proto",    32'(out_proto_err), 32'd0);

    // Fill to 15 with the sink blocked, then overflow
    ready = 1'b0;
    burst(5, 8'h10, 1'b0, 1'b1);
    check("t2_level5",  32'(out_level), 32'd5);
    check("t2_stall5",  32'(out_stall), 32'd0);
    burst(5, 8'h15, 1'b0, 1'b1);
    check("t2_level10", 32'(out_level), 32'd10);
    check("t2_stall10", 32'(out_stall), 32'd0);
    burst(5, 8'h1A, 1'b0, 1'b1);
    check("t2_level15", 32'(out_level), 32'd15);
    check("t2_stall15", 32'(out_stall), 32'd1);
    check("t2_no_ovf_yet", 32'(out_overflow), 32'd0);
    burst(5, 8'hE0, 1'b0, 1'b0);
    check("t2_level_after_drop", 32'(out_level),     32'd15);
    check("t2_overflow",         32'(out_overflow),  32'd1);
    check("t2_proto",            32'(out_proto_err), 32'd0);
    drain("t2_drain", 40);
    check("t2_stall_empty",  32'(out_stall),    32'd0);
    check("t2_ovf_sticky",   32'(out_overflow), 32'd1);

    // Pointer wrap with simultaneous write and pop
    do_reset();
    check("t3_ovf_cleared", 32'(out_overflow), 32'd0);
    burst(5, 8'h20, 1'b0, 1'b1);
    burst(5, 8'h25, 1'b0, 1'b1);
    burst(4, 8'h2A, 1'b0, 1'b1);
    check("t3_level14", 32'(out_level), 32'd14);
    check("t3_stall14", 32'(out_stall), 32'd1);
    ready = 1'b1;
    repeat (10) tick();
    check("t3_level4", 32'(out_level), 32'd4);
    burst(5, 8'h30, 1'b0, 1'b1);
    check("t3_level8", 32'(out_level), 32'd8);
    drain("t3_drain", 20);

    // Frame end with two bytes: F1 tagged last, done one cycle after its handshake
    ready = 1'b1;
    burst(2, 8'hF0, 1'b1, 1'b1);
    check("t4_level2",  32'(out_level), 32'd2);
    check("t4_last_f0", 32'(out_last),  32'd0);
    check("t4_done0",   32'(out_done),  32'd0);
    tick();
    check("t4_last_f1", 32'(out_last),  32'd1);
    check("t4_byte_f1", 32'(out_byte),  32'hF1);
    tick();
    check("t4_done1",   32'(out_done),  32'd1);
    check("t4_valid0",  32'(out_valid), 32'd0);
    tick();
    check("t4_done_pulse", 32'(out_done), 32'd0);

    // Empty frame: FLUSH then DONE, never a last tag
    burst(0, 8'h00, 1'b1, 1'b0);
    check("t5_done0", 32'(out_done), 32'd0);
    check("t5_last0", 32'(out_last), 32'd0);
    tick();
    check("t5_done1", 32'(out_done), 32'd1);
    check("t5_last1", 32'(out_last), 32'd0);
    tick();
    check("t5_done_pulse", 32'(out_done),      32'd0);
    check("t5_proto0",     32'(out_proto_err), 32'd0);
    burst(6, 8'h60, 1'b0, 1'b0);
    check("t5_proto_cnt6", 32'(out_proto_err), 32'd1);
    check("t5_level_cnt6", 32'(out_level),     32'd0);

    // Asynchronous reset in the middle of a flush
    ready = 1'b0;
    burst(3, 8'h50, 1'b1, 1'b1);
    check("t6_valid_pre", 32'(out_valid), 32'd1);
    check("t6_level_pre", 32'(out_level), 32'd3);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t6_valid",  32'(out_valid),     32'd0);
    check("t6_level",  32'(out_level),     32'd0);
    check("t6_last",   32'(out_last),      32'd0);
    check("t6_done",   32'(out_done),      32'd0);
    check("t6_proto",  32'(out_proto_err), 32'd0);
    check("t6_ovf",    32'(out_overflow),  32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    // Back in IDLE: a one-byte frame is accepted and completes normally
    ready = 1'b1;
    burst(1, 8'h77, 1'b1, 1'b1);
    check("t6_post_last",  32'(out_last),      32'd1);
    check("t6_post_byte",  32'(out_byte),      32'h77);
    check("t6_post_proto", 32'(out_proto_err), 32'd0);
    tick();
    check("t6_post_done",  32'(out_done),      32'd1);
    tick();
    check("t6_post_done_pulse", 32'(out_done), 32'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bitstream_output_scheduler.md
Name: bitstream_output_scheduler

Overview:
Sits after stage 4 and turns its bursty carry-propagated output (0-5 bytes per cycle plus a 3-bit byte count) into a single-byte valid/ready stream for the bitstream sink. A byte FIFO with a multi-write port absorbs the bursts, and a stall output throttles the upstream pipeline. A small FSM sequences the end of frame: flush the FIFO, tag the last byte, pulse done.

Parameters:
BYTE_WIDTH, 8, width of one bitstream byte
FIFO_DEPTH, 16, byte entries; power of 2, minimum 8
LEVEL_WIDTH, $clog2(FIFO_DEPTH)+1, occupancy counter width

Ports:
s5_clk  in  1  clock
s5_reset  in  1  asynchronous, active-low reset
in_carry_flag  in  3  number of valid bytes this cycle, 0..5
in_carry_bit_1..in_carry_bit_5  in  BYTE_WIDTH each  burst bytes; bit_1 is first in stream order
in_flag_last  in  1  the burst on this cycle is the final burst of the frame
in_sink_ready  in  1  downstream accepts out_byte
out_byte  out  BYTE_WIDTH  FIFO head byte
out_valid  out  1  out_byte is valid
out_last  out  1  out_byte is the last byte of the frame
out_done  out  1  one-cycle pulse when the frame is fully drained
out_stall  out  1  upstream must not present a new burst
out_level  out  LEVEL_WIDTH  current occupancy
out_overflow  out  1  sticky: a burst was dropped for lack of space
out_proto_err  out  1  sticky: illegal count, or a write after the last burst

Behaviour:
- Reset (s5_reset=0, async):
  - rd_ptr, wr_ptr and level go to 0; state goes to IDLE.
  - All outputs go to 0. FIFO storage is not reset.
- States: IDLE, RUN, FLUSH, DONE.
  - IDLE -> RUN on the first burst with count >0.
  - IDLE/RUN -> FLUSH on in_flag_last=1. That cycle's burst is written first, if legal.
  - FLUSH -> DONE on the handshake of the byte with out_last=1, or on the first FLUSH cycle with level=0.
  - DONE -> IDLE unconditionally after one cycle; out_done=1 only in DONE.
- Write:
  - In IDLE/RUN, when 1 <= count <= 5 and free = FIFO_DEPTH-level >= count, write bytes 1..count at wr_ptr..wr_ptr+count-1 modulo FIFO_DEPTH.
  - wr_ptr advances by count.
- Overflow: if count > free, drop the whole burst (no partial write) and set out_overflow.
- Count 6 or 7: ignored; sets out_proto_err.
- Any count >0 in FLUSH or DONE: ignored; sets out_proto_err.
- Read (first-word fall-through):
  - out_valid = (level != 0); out_byte = mem[rd_ptr].
  - Pop on out_valid & in_sink_ready; rd_ptr increments modulo FIFO_DEPTH.
  - out_byte and out_last are held stable while valid & !ready.
- Level update: level_next = level + accepted_count - pop, with write and pop legal in the same cycle.
- Latency: a byte written at edge N is visible on out_byte after edge N, i.e. in cycle N+1.
- out_stall = (FIFO_DEPTH - level) < 5, combinational from registered level. It ignores same-cycle pops (conservative).
- out_last = out_valid & (state==FLUSH) & (level==1).
- Pointer wrap: indices use the low $clog2(FIFO_DEPTH) bits; level distinguishes full from empty.
- Reset mid-frame (any state): the frame is discarded, no out_done, and sticky errors clear.

Decomposition:
- Package bitstream_pkg holds:
  - constant BURST_MAX=5 and the 3-bit count width;
  - FSM state typedef/localparams (IDLE=0, RUN=1, FLUSH=2, DONE=3);
  - BYTE_WIDTH default.
- One sub-module: byte_fifo_multi_write, a circular buffer with a 5-lane write port (count-masked) and a single FWFT read port, owning pointers and level.
- The FSM, error flags and out_last/out_done logic stay in the top module.

Test Plan:
- Reset released, in_sink_ready=1, burst count=3 {A1,A2,A3} -> out_byte A1, A2, A3 on the three cycles after the write edge; level returns to 0; no errors.
- in_sink_ready=0, three bursts of 5 -> level=15 and out_stall=1 after the third; a forced fourth burst -> dropped, level stays 15, out_overflow=1.
- level=4, burst count=5 with a same-cycle pop -> level=8 next cycle; byte order preserved across the pointer wrap (writes at indices 14, 15, 0, 1, 2).
- Burst count=2 {F0,F1} with in_flag_last=1 -> FLUSH; F1 is presented with out_last=1; out_done pulses one cycle after the F1 handshake, then IDLE.
- in_carry_flag=0 with in_flag_last=1 and an empty FIFO -> FLUSH then DONE, out_done=1 for one cycle, out_last never asserted. In_carry_flag=6 at any time -> ignored, out_proto_err=1.
- Assert s5_reset=0 mid-FLUSH with level=3 -> out_valid, out_level, out_last and sticky flags go to 0 immediately, without waiting for a clock edge; after release the state is IDLE.
